// File: rtl/hash_tx_scheduler.sv
// Queues 256-bit mining results and feeds them one at a time to the hex-ASCII
// UART transmitter, holding each word stable for the whole frame.
`timescale 1ns/1ps
module hash_tx_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DW     = 256,
    parameter int DROP_W = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic                   i_Res_Valid,
    input  logic [DW-1:0]          i_Res_Data,
    output logic                   o_Tx_DV,
    output logic [DW-1:0]          o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Full,
    output logic [$clog2(DEPTH):0] o_Level,
    output logic                   o_Busy,
    output logic [DROP_W-1:0]      o_Drop_Count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_ACT,
        S_WAIT_DONE,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wrPtr_q, rdPtr_q;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     txByte_q, txByte_d;
    logic              txDv_q, txDv_d;
    logic [DROP_W-1:0] dropCnt_q, dropCnt_d;
    logic              full, empty, push, drop, pop;

    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty = (wrPtr_q == rdPtr_q);
    assign push  = i_Res_Valid && !full;
    assign drop  = i_Res_Valid && full;

    // Only launch when the transmitter is fully idle, so a reset mid-frame
    // never strobes into a frame the transmitter is still finishing.
    always_comb begin
        state_d  = state_q;
        txByte_d = txByte_q;
        txDv_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !i_Tx_Active && !i_Tx_Done) begin
                    pop      = 1'b1;
                    txByte_d = mem_q[rdPtr_q[AW-1:0]];
                    txDv_d   = 1'b1;
                    state_d  = S_STROBE;
                end
            end
            S_STROBE:    state_d = S_WAIT_ACT;
            S_WAIT_ACT:  if (i_Tx_Active) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (i_Tx_Done) state_d = S_DRAIN;
            S_DRAIN:     if (!i_Tx_Done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (drop && (dropCnt_q != {DROP_W{1'b1}})) begin
            dropCnt_d = dropCnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            txByte_q  <= '0;
            txDv_q    <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txByte_q  <= txByte_d;
            txDv_q    <= txDv_d;
            dropCnt_q <= dropCnt_d;
            if (push) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (pop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wrPtr_q[AW-1:0]] <= i_Res_Data;
    end

    assign o_Tx_DV      = txDv_q;
    assign o_Tx_Byte    = txByte_q;
    assign o_Full       = full;
    assign o_Level      = wrPtr_q - rdPtr_q;
    assign o_Busy       = (state_q != S_IDLE);
    assign o_Drop_Count = dropCnt_q;

endmodule

// File: tb/tb_hash_tx_scheduler.sv
// Directed and randomised bench for hash_tx_scheduler with a behavioural
// transmitter model and a spec-level reference for ordering and drops.
`timescale 1ns/1ps
module tb_hash_tx_scheduler;
    localparam int DEPTH  = 4;
    localparam int DW     = 256;
    localparam int DROP_W = 4;
    localparam int SAT    = (1 << DROP_W) - 1;

    logic              clk;
    logic              rstN;
    logic              resValid;
    logic [DW-1:0]     resData;
    logic              txDv;
    logic [DW-1:0]     txByte;
    logic              txActive;
    logic              txDone;
    logic              full;
    logic [2:0]        level;
    logic              busy;
    logic [DROP_W-1:0] dropCount;

    int            vectors = 0;
    int            fails   = 0;
    logic [DW-1:0] sentQ[$];
    logic [DW-1:0] pushedQ[$];
    logic          txStall  = 1'b0;
    logic          capValid = 1'b0;
    logic [DW-1:0] capWord  = '0;
    int            txPhase  = 0;
    int            txCnt    = 0;
    logic          dvPrev   = 1'b0;

    hash_tx_scheduler #(.DEPTH(DEPTH), .DW(DW), .DROP_W(DROP_W)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rstN),
        .i_Res_Valid (resValid),
        .i_Res_Data  (resData),
        .o_Tx_DV     (txDv),
        .o_Tx_Byte   (txByte),
        .i_Tx_Active (txActive),
        .i_Tx_Done   (txDone),
        .o_Full      (full),
        .o_Level     (level),
        .o_Busy      (busy),
        .o_Drop_Count(dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data);
        resValid = valid;
        resData  = data;
        tick();
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((busy || level != 0 || txPhase != 0 || txDone) && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, DW'(n < 2000), DW'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dv"},    DW'(txDv),      DW'(0));
        checkOutput({tag, "_byte"},  txByte,         '0);
        checkOutput({tag, "_full"},  DW'(full),      DW'(0));
        checkOutput({tag, "_level"}, DW'(level),     DW'(0));
        checkOutput({tag, "_busy"},  DW'(busy),      DW'(0));
        checkOutput({tag, "_drop"},  DW'(dropCount), DW'(0));
    endtask

    // Transmitter model: goes active on a strobe, runs a random-length frame,
    // then raises Done for two cycles. It has no reset, like the real one.
    initial begin
        txActive = 1'b0;
        txDone   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            checkOutput("dv_single_cycle", DW'(dvPrev && txDv), DW'(0));
            if (txDv) checkOutput("dv_while_tx_busy", DW'(txActive || txDone), DW'(0));
            dvPrev = txDv;
            if (txPhase == 0) begin
                if (txDv && !txStall) begin
                    capWord  = txByte;
                    capValid = 1'b1;
                    sentQ.push_back(txByte);
                    txActive = 1'b1;
                    txCnt    = int'($urandom_range(6, 12));
                    txPhase  = 1;
                end
            end else begin
                if (capValid) checkOutput("byte_hold", txByte, capWord);
                txCnt--;
                if (txPhase == 1 && txCnt == 0) begin
                    txActive = 1'b0;
                    txDone   = 1'b1;
                    txCnt    = 2;
                    txPhase  = 2;
                end else if (txPhase == 2 && txCnt == 0) begin
                    txDone  = 1'b0;
                    txPhase = 0;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] word0, newWord, w;
        logic [DW-1:0] bw[6];
        logic [DW-1:0] rw[4];
        int            expLevel[6] = '{1, 1, 2, 3, 4, 4};
        int            n, nDrop, expDrop, pushes, j;

        rstN     = 1'b0;
        resValid = 1'b0;
        resData  = '0;
        tick();
        tick();
        checkResetState("reset");
        rstN = 1'b1;
        tick();

        $display("[TB] single result into idle scheduler");
        word0 = {4{64'h0123456789ABCDEF}};
        applyStimulus(1'b1, word0);
        checkOutput("single_level_after_push", DW'(level), DW'(1));
        checkOutput("single_dv_not_yet",       DW'(txDv),  DW'(0));
        applyStimulus(1'b0, '0);
        checkOutput("single_dv_latency",   DW'(txDv),  DW'(1));
        checkOutput("single_byte",         txByte,     word0);
        checkOutput("single_level_popped", DW'(level), DW'(0));
        checkOutput("single_busy",         DW'(busy),  DW'(1));
        tick();
        checkOutput("single_dv_fall", DW'(txDv), DW'(0));
        n = 0;
        while (txPhase != 0 && n < 200) begin
            if (txDone) checkOutput("single_busy_during_done", DW'(busy), DW'(1));
            tick();
            n++;
        end
        checkOutput("single_wait_frame", DW'(n < 200), DW'(1));
        checkOutput("single_busy_after_done", DW'(busy), DW'(0));
        checkOutput("single_sent_count", DW'(sentQ.size()), DW'(1));
        if (sentQ.size() > 0) checkOutput("single_sent_word", sentQ[0], word0);
        checkOutput("single_drop", DW'(dropCount), DW'(0));

        $display("[TB] burst of six strobes");
        sentQ.delete();
        for (int k = 0; k < 6; k++) begin
            bw[k] = rand256();
            applyStimulus(1'b1, bw[k]);
            checkOutput($sformatf("burst_level_%0d", k), DW'(level), DW'(expLevel[k]));
            checkOutput($sformatf("burst_full_%0d", k), DW'(full), DW'(k >= 4));
        end
        resValid = 1'b0;
        checkOutput("burst_drop", DW'(dropCount), DW'(1));
        expDrop = 1;

        n = 0;
        while (!txDone && n < 200) begin
            tick();
            n++;
        end
        checkOutput("fullpop_wait_done", DW'(n < 200), DW'(1));
        nDrop = 0;
        do begin
            applyStimulus(1'b1, rand256());
            nDrop++;
        end while (!txDv && nDrop < 50);
        resValid = 1'b0;
        checkOutput("fullpop_wait_dv", DW'(nDrop < 50), DW'(1));
        expDrop = (expDrop + nDrop > SAT) ? SAT : expDrop + nDrop;
        checkOutput("fullpop_level", DW'(level), DW'(3));
        checkOutput("fullpop_drop", DW'(dropCount), DW'(expDrop));
        checkOutput("fullpop_byte", txByte, bw[1]);
        waitIdle("burst_drain");
        checkOutput("burst_sent_count", DW'(sentQ.size()), DW'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < sentQ.size()) checkOutput($sformatf("burst_order_%0d", k), sentQ[k], bw[k]);
        end

        $display("[TB] reset mid-frame with entries queued");
        sentQ.delete();
        for (int k = 0; k < 4; k++) begin
            rw[k] = rand256();
            applyStimulus(1'b1, rw[k]);
        end
        resValid = 1'b0;
        n = 0;
        while (!txActive && n < 50) begin
            tick();
            n++;
        end
        checkOutput("midreset_wait_active", DW'(n < 50), DW'(1));
        checkOutput("midreset_level_before", DW'(level), DW'(3));
        capValid = 1'b0;
        rstN     = 1'b0;
        tick();
        rstN = 1'b1;
        checkResetState("midreset");
        newWord = rand256();
        applyStimulus(1'b1, newWord);
        resValid = 1'b0;
        checkOutput("midreset_level_push", DW'(level), DW'(1));
        checkOutput("midreset_no_launch",  DW'(busy),  DW'(0));
        waitIdle("midreset_drain");
        checkOutput("midreset_sent_count", DW'(sentQ.size()), DW'(2));
        if (sentQ.size() > 1) begin
            checkOutput("midreset_inflight", sentQ[0], rw[0]);
            checkOutput("midreset_new_word", sentQ[1], newWord);
        end

        $display("[TB] random traffic");
        sentQ.delete();
        pushes = 0;
        for (int c = 0; c < 80; c++) begin
            if (pushes < 14 && $urandom_range(0, 5) == 0) begin
                w = rand256();
                pushedQ.push_back(w);
                pushes++;
                applyStimulus(1'b1, w);
            end else begin
                applyStimulus(1'b0, '0);
            end
        end
        waitIdle("random_drain");
        expDrop = pushes - sentQ.size();
        checkOutput("random_drop_balance", DW'(dropCount), DW'(expDrop));
        j = 0;
        foreach (sentQ[s]) begin
            while (j < pushes && pushedQ[j] !== sentQ[s]) j++;
            checkOutput($sformatf("random_order_%0d", s), DW'(j < pushes), DW'(1));
            j++;
        end

        $display("[TB] drop counter saturation with stalled transmitter");
        txStall = 1'b1;
        for (int k = 0; k < 25; k++) applyStimulus(1'b1, rand256());
        expDrop = (expDrop + 20 > SAT) ? SAT : expDrop + 20;
        checkOutput("sat_drop",  DW'(dropCount), DW'(expDrop));
        checkOutput("sat_level", DW'(level),     DW'(4));
        checkOutput("sat_full",  DW'(full),      DW'(1));
        checkOutput("sat_busy",  DW'(busy),      DW'(1));
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, rand256());
        resValid = 1'b0;
        checkOutput("sat_drop_hold", DW'(dropCount), DW'(SAT));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
